// File: rtl/keypad_pkg.sv
// Shared keypad types: debouncer FSM states, scanner sign/class codes, key tuple width.
package keypad_pkg;

  localparam int KEY_TUPLE_W = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_EMIT,
    ST_HELD,
    ST_RELEASE
  } key_state_t;

  localparam logic [2:0] SIGN_NONE  = 3'b000;
  localparam logic [2:0] SIGN_MINUS = 3'b100;
  localparam logic [2:0] SIGN_PLUS  = 3'b010;
  localparam logic [2:0] SIGN_A     = 3'b001;
  localparam logic [2:0] SIGN_BC    = 3'b011;
  localparam logic [2:0] SIGN_D     = 3'b111;

  function automatic logic is_digit(input logic [2:0] sign);
    return (sign == SIGN_NONE);
  endfunction

endpackage

// File: rtl/key_debouncer_stable_counter.sv
// 8-bit stability counter: clear has priority, enable increments (saturating), tc_o flags TERMINAL.
module stable_counter #(
  parameter logic [7:0] TERMINAL = 8'd3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'd0;
    end else if (en_i && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TERMINAL);

endmodule

// File: rtl/key_debouncer.sv
// Keypad debouncer: qualifies scanner samples, pulses key_valid once per accepted press, freezes the column scan.
// Optional auto-repeat of held digit keys when KEY_REPEAT_EN is defined.
module key_debouncer
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int RELEASE_CYCLES  = 4,
  parameter int REPEAT_CYCLES   = 16
) (
  input  logic       slow_clk,
  input  logic       rst,
  input  logic       key_pressed_in,
  input  logic [3:0] key_value_in,
  input  logic [2:0] is_sign_key_in,
  output logic       scan_hold,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [2:0] key_sign,
  output logic       key_down
);

  if ((DEBOUNCE_CYCLES < 2) || (DEBOUNCE_CYCLES > 255) ||
      (RELEASE_CYCLES < 2)  || (RELEASE_CYCLES > 255)  ||
      (REPEAT_CYCLES < 2)   || (REPEAT_CYCLES > 65535)) begin : g_bad_params
    $error("key_debouncer: parameter out of legal range");
  end

  localparam logic [7:0] DB_TC  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] REL_TC = 8'(RELEASE_CYCLES - 1);

  key_state_t             state_q;
  logic [KEY_TUPLE_W-1:0] cand_q;
  logic                   scan_hold_q;
  logic                   key_valid_q;
  logic [3:0]             key_code_q;
  logic [2:0]             key_sign_q;
  logic                   key_down_q;

  logic [KEY_TUPLE_W-1:0] tuple;
  logic                   match;
  logic                   db_en, db_clr, db_tc;
  logic                   rel_en, rel_clr, rel_tc;

`ifdef KEY_REPEAT_EN
  localparam logic [15:0] RPT_TC = 16'(REPEAT_CYCLES - 1);
  logic [15:0] rpt_q;
`endif

  assign tuple = {key_value_in, is_sign_key_in};
  assign match = (tuple == cand_q);

  always_comb begin
    db_en  = 1'b0;
    rel_en = 1'b0;
    case (state_q)
      ST_IDLE:     db_en  = key_pressed_in;
      ST_DEBOUNCE: db_en  = key_pressed_in && match && !db_tc;
      ST_HELD:     rel_en = !key_pressed_in;
      ST_RELEASE:  rel_en = !key_pressed_in && !rel_tc;
      default:     ;
    endcase
  end

  // Any cycle a counter is not advancing it returns to zero, so both sit at 0 outside their phase.
  assign db_clr  = !db_en;
  assign rel_clr = !rel_en;

  stable_counter #(.TERMINAL(DB_TC)) u_db_cnt (
    .clk_i (slow_clk),
    .rst_i (rst),
    .clr_i (db_clr),
    .en_i  (db_en),
    .tc_o  (db_tc)
  );

  stable_counter #(.TERMINAL(REL_TC)) u_rel_cnt (
    .clk_i (slow_clk),
    .rst_i (rst),
    .clr_i (rel_clr),
    .en_i  (rel_en),
    .tc_o  (rel_tc)
  );

  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cand_q      <= '0;
      scan_hold_q <= 1'b0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
      key_sign_q  <= 3'd0;
      key_down_q  <= 1'b0;
`ifdef KEY_REPEAT_EN
      rpt_q       <= 16'd0;
`endif
    end else begin
      key_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (key_pressed_in) begin
            cand_q      <= tuple;
            state_q     <= ST_DEBOUNCE;
            scan_hold_q <= 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          if (!key_pressed_in || !match) begin
            cand_q      <= '0;
            state_q     <= ST_IDLE;
            scan_hold_q <= 1'b0;
          end else if (db_tc) begin
            state_q     <= ST_EMIT;
            key_valid_q <= 1'b1;
            key_code_q  <= cand_q[KEY_TUPLE_W-1:3];
            key_sign_q  <= cand_q[2:0];
            key_down_q  <= 1'b1;
          end
        end
        ST_EMIT: begin
          state_q <= ST_HELD;
`ifdef KEY_REPEAT_EN
          // The EMIT cycle counts as the first of the repeat interval.
          rpt_q   <= 16'd1;
`endif
        end
        ST_HELD: begin
          if (!key_pressed_in) begin
            state_q <= ST_RELEASE;
`ifdef KEY_REPEAT_EN
            rpt_q   <= 16'd0;
`endif
          end
`ifdef KEY_REPEAT_EN
          else if (rpt_q == RPT_TC) begin
            rpt_q <= 16'd0;
            if (is_digit(key_sign_q)) begin
              key_valid_q <= 1'b1;
            end
          end else begin
            rpt_q <= rpt_q + 16'd1;
          end
`endif
        end
        ST_RELEASE: begin
          if (key_pressed_in) begin
            state_q <= ST_HELD;
          end else if (rel_tc) begin
            state_q     <= ST_IDLE;
            scan_hold_q <= 1'b0;
            key_down_q  <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          scan_hold_q <= 1'b0;
          key_down_q  <= 1'b0;
        end
      endcase
    end
  end

  assign scan_hold = scan_hold_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_sign  = key_sign_q;
  assign key_down  = key_down_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer at default parameters; repeat expectations follow KEY_REPEAT_EN.
module tb_key_debouncer;
  import keypad_pkg::*;

  logic       slow_clk = 1'b0;
  logic       rst = 1'b1;
  logic       kp = 1'b0;
  logic [3:0] kv = 4'd0;
  logic [2:0] ks = 3'd0;
  logic       scan_hold, key_valid, key_down;
  logic [3:0] key_code;
  logic [2:0] key_sign;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  int pq[$];
  int s;

  key_debouncer dut (
    .slow_clk       (slow_clk),
    .rst            (rst),
    .key_pressed_in (kp),
    .key_value_in   (kv),
    .is_sign_key_in (ks),
    .scan_hold      (scan_hold),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .key_sign       (key_sign),
    .key_down       (key_down)
  );

  always #5 slow_clk = ~slow_clk;

  always @(posedge slow_clk) cyc_n <= cyc_n + 1;

  always @(negedge slow_clk) if (key_valid) pq.push_back(cyc_n);

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic p, input logic [3:0] v, input logic [2:0] sg, input int n);
    for (int i = 0; i < n; i++) begin
      kp = p;
      kv = v;
      ks = sg;
      @(posedge slow_clk);
      #1;
    end
  endtask

  function automatic int pulse_at(input int idx);
    if (idx < pq.size()) return pq[idx];
    return -1;
  endfunction

  initial begin
    #12;
    check_eq("rst_outputs", {27'd0, scan_hold, key_valid, key_down, key_code != 4'd0, key_sign != 3'd0}, 0);
    rst = 1'b0;
    @(posedge slow_clk);
    #1;
    drive(1'b0, 4'd0, SIGN_NONE, 2);

    // Clean press of '5'
    pq.delete();
    s = cyc_n;
    drive(1'b1, 4'b0101, SIGN_NONE, 1);
    check_eq("t1_hold_t0p1", scan_hold, 1);
    check_eq("t1_down_deb", key_down, 0);
    drive(1'b1, 4'b0101, SIGN_NONE, 9);
    check_eq("t1_down_held", key_down, 1);
    drive(1'b0, 4'd0, SIGN_NONE, 3);
    check_eq("t1_hold_rel3", scan_hold, 1);
    check_eq("t1_down_rel3", key_down, 1);
    drive(1'b0, 4'd0, SIGN_NONE, 1);
    check_eq("t1_hold_rel4", scan_hold, 0);
    check_eq("t1_down_rel4", key_down, 0);
    check_eq("t1_npulse", pq.size(), 1);
    check_eq("t1_pulse_cyc", pulse_at(0), s + 4);
    check_eq("t1_code", key_code, 5);
    check_eq("t1_sign", key_sign, 0);

    // Bouncy press of '7'
    pq.delete();
    drive(1'b1, 4'b0111, SIGN_NONE, 2);
    drive(1'b0, 4'd0, SIGN_NONE, 1);
    s = cyc_n;
    drive(1'b1, 4'b0111, SIGN_NONE, 6);
    drive(1'b0, 4'd0, SIGN_NONE, 6);
    check_eq("t2_npulse", pq.size(), 1);
    check_eq("t2_pulse_cyc", pulse_at(0), s + 4);
    check_eq("t2_code", key_code, 7);

    // '0' then '#': same value, different class
    pq.delete();
    s = cyc_n;
    drive(1'b1, 4'b0000, SIGN_NONE, 2);
    drive(1'b1, 4'b0000, SIGN_PLUS, 6);
    drive(1'b0, 4'd0, SIGN_NONE, 6);
    check_eq("t3_npulse", pq.size(), 1);
    check_eq("t3_pulse_cyc", pulse_at(0), s + 7);
    check_eq("t3_code", key_code, 0);
    check_eq("t3_sign", key_sign, 2);

    // Release bounce on 'A'
    pq.delete();
    drive(1'b1, 4'b1010, SIGN_A, 6);
    drive(1'b0, 4'd0, SIGN_NONE, 2);
    drive(1'b1, 4'b1010, SIGN_A, 1);
    drive(1'b0, 4'd0, SIGN_NONE, 3);
    check_eq("t4_down_before", key_down, 1);
    drive(1'b0, 4'd0, SIGN_NONE, 1);
    check_eq("t4_down_after", key_down, 0);
    check_eq("t4_hold_after", scan_hold, 0);
    drive(1'b0, 4'd0, SIGN_NONE, 1);
    check_eq("t4_npulse", pq.size(), 1);
    check_eq("t4_sign", key_sign, 1);

    // One sample short of acceptance, then exactly enough
    pq.delete();
    drive(1'b1, 4'b1011, SIGN_BC, 3);
    drive(1'b0, 4'd0, SIGN_NONE, 3);
    check_eq("short_npulse", pq.size(), 0);
    check_eq("short_hold", scan_hold, 0);
    s = cyc_n;
    drive(1'b1, 4'b1110, SIGN_MINUS, 4);
    drive(1'b0, 4'd0, SIGN_NONE, 6);
    check_eq("exact_npulse", pq.size(), 1);
    check_eq("exact_pulse_cyc", pulse_at(0), s + 4);
    check_eq("exact_sign", key_sign, 4);
    check_eq("exact_down", key_down, 0);

    // Async reset mid-HELD with '3' still pressed
    drive(1'b1, 4'b0011, SIGN_NONE, 6);
    #2 rst = 1'b1;
    #1;
    check_eq("t5_async_code", key_code, 0);
    check_eq("t5_async_ctl", {29'd0, scan_hold, key_valid, key_down}, 0);
    @(posedge slow_clk);
    #1;
    rst = 1'b0;
    pq.delete();
    s = cyc_n;
    drive(1'b1, 4'b0011, SIGN_NONE, 8);
    drive(1'b0, 4'd0, SIGN_NONE, 6);
    check_eq("t5_npulse", pq.size(), 1);
    check_eq("t5_pulse_cyc", pulse_at(0), s + 4);
    check_eq("t5_code", key_code, 3);

    // '9' held 40 cycles past EMIT
    pq.delete();
    s = cyc_n;
    drive(1'b1, 4'b1001, SIGN_NONE, 45);
    drive(1'b0, 4'd0, SIGN_NONE, 8);
`ifdef KEY_REPEAT_EN
    check_eq("t6_npulse", pq.size(), 3);
    check_eq("t6_pulse1", pulse_at(1), s + 20);
    check_eq("t6_pulse2", pulse_at(2), s + 36);
`else
    check_eq("t6_npulse", pq.size(), 1);
`endif
    check_eq("t6_pulse0", pulse_at(0), s + 4);
    check_eq("t6_code", key_code, 9);

    // 'D' held just as long never repeats
    pq.delete();
    s = cyc_n;
    drive(1'b1, 4'b1101, SIGN_D, 45);
    drive(1'b0, 4'd0, SIGN_NONE, 8);
    check_eq("t6d_npulse", pq.size(), 1);
    check_eq("t6d_pulse0", pulse_at(0), s + 4);
    check_eq("t6d_sign", key_sign, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
